branch_predictor: RTL and testbench

Bimodal branch direction predictor: a table of 2-bit saturating counters indexed by branch address bits [11:2]. It gives a taken/not-taken prediction for the addressed entry and trains that entry with the resolved outcome when an update is requested. It sits in the fetch/decode front end: fetch supplies `branch_address` and reads `prediction`, and the execute-stage resolution drives `branch_req` and `branch_result`.

---
 rtl/branch_predictor.sv | 73 +++++++
 tb/tb_branch_predictor.sv | 131 +++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: a table of 2-bit saturating counters indexed by branch_address[IDX_W+1:2].
// Define BP_REG_PRED_EN to register the prediction output; otherwise prediction is combinational.
module branch_predictor #(
  parameter int NUM_BRANCH_TABLE_ENTRIES = 1024
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [11:2] branch_address,
  input  logic        branch_req,
  input  logic        branch_result,
  output logic        prediction
);

  localparam int IDX_W = $clog2(NUM_BRANCH_TABLE_ENTRIES);

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       table_r [NUM_BRANCH_TABLE_ENTRIES];
  logic [1:0]       cur_s;
  logic [1:0]       next_s;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    case ({taken, ctr})
      3'b1_11: res = 2'b11;
      3'b0_00: res = 2'b00;
      3'b1_00, 3'b1_01, 3'b1_10: res = ctr + 2'd1;
      3'b0_01, 3'b0_10, 3'b0_11: res = ctr - 2'd1;
      default: res = 2'b01;
    endcase
    return res;
  endfunction

  assign idx_s = branch_address[IDX_W+1:2];

  // Read the addressed counter and form its trained value.
  always_comb begin
    cur_s  = table_r[idx_s];
    next_s = sat_update(cur_s, branch_result);
  end

  for (genvar g = 0; g < NUM_BRANCH_TABLE_ENTRIES; g++) begin : g_entry
    // Counter storage: reset to weakly not taken, train only the indexed entry.
    always_ff @(posedge clk) begin
      if (rst_b) begin
        table_r[g] <= 2'b01;
      end else if (branch_req && (idx_s == IDX_W'(g))) begin
        table_r[g] <= next_s;
      end else begin
        table_r[g] <= table_r[g];
      end
    end
  end

`ifdef BP_REG_PRED_EN
  logic pred_r;

  // Registered prediction: read and write share the index, so the post-update value is next_s when training.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      pred_r <= 1'b0;
    end else if (branch_req) begin
      pred_r <= next_s[1];
    end else begin
      pred_r <= cur_s[1];
    end
  end

  assign prediction = pred_r;
`else
  assign prediction = cur_s[1];
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test plan, random training and a full-table sweep
// against an integer saturating-counter model.
module tb_branch_predictor;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [9:0] branch_address;
  logic       branch_req;
  logic       branch_result;
  logic       prediction;

  int model [1024];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .branch_address (branch_address),
    .branch_req     (branch_req),
    .branch_result  (branch_result),
    .prediction     (prediction)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; prediction is compared before (combinational build) and after the edge.
  task automatic step(input logic [9:0] a, input logic req, input logic res, input logic rst);
    @(negedge clk);
    branch_address = a;
    branch_req     = req;
    branch_result  = res;
    rst_b          = rst;
`ifndef BP_REG_PRED_EN
    #1 check("pre_edge", {31'd0, prediction}, (model[a] >= 2) ? 1 : 0);
`endif
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 1024; i++) model[i] = 1;
    end else if (req) begin
      if (res) model[a] = (model[a] == 3) ? 3 : model[a] + 1;
      else     model[a] = (model[a] == 0) ? 0 : model[a] - 1;
    end
    #1 check("post_edge", {31'd0, prediction}, (model[a] >= 2) ? 1 : 0);
  endtask

  task automatic check_ctr(input string tag, input logic [9:0] a);
    check(tag, {30'd0, dut.table_r[a]}, model[a]);
  endtask

  initial begin
    logic [9:0] a;
    logic [9:0] corner [4];
    corner[0] = 10'h000;
    corner[1] = 10'h001;
    corner[2] = 10'h3FE;
    corner[3] = 10'h3FF;

    rst_b          = 1'b1;
    branch_req     = 1'b0;
    branch_result  = 1'b0;
    branch_address = 10'h000;
    @(posedge clk);
    for (int i = 0; i < 1024; i++) model[i] = 1;
    #1 check("reset_pred", {31'd0, prediction}, 0);

    for (int i = 0; i < 4; i++) begin
      step(corner[i], 1'b0, 1'b0, 1'b0);
      check_ctr("reset_ctr", corner[i]);
    end

    for (int i = 0; i < 3; i++) begin
      step(10'h000, 1'b1, 1'b1, 1'b0);
      check_ctr("train_up_ctr", 10'h000);
    end

    for (int i = 0; i < 4; i++) begin
      step(10'h000, 1'b1, 1'b0, 1'b0);
      check_ctr("train_down_ctr", 10'h000);
    end

    step(10'h000, 1'b1, 1'b1, 1'b0);
    step(10'h000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(10'h001, 1'b0, i[0], 1'b0);
      check_ctr("hold_ctr", 10'h001);
    end
    step(10'h000, 1'b0, 1'b1, 1'b0);
    check_ctr("hold_trained_ctr", 10'h000);

    for (int i = 0; i < 4; i++) step(10'h3FE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(10'h3FF, 1'b1, 1'b1, 1'b0);
    check_ctr("iso_3fe_ctr", 10'h3FE);
    check_ctr("iso_3ff_ctr", 10'h3FF);
    step(10'h3FE, 1'b0, 1'b0, 1'b0);
    step(10'h3FD, 1'b0, 1'b0, 1'b0);
    check_ctr("iso_3fd_ctr", 10'h3FD);
    check_ctr("iso_001_ctr", 10'h001);

    step(10'h3FF, 1'b1, 1'b1, 1'b1);
    check_ctr("rst_prio_ctr", 10'h3FF);

    // Random training, mostly on a small address pool so counters saturate and alias checks bite.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 10'($urandom_range(0, 1023));
        1:       a = 10'h3F8 | 10'($urandom_range(0, 7));
        default: a = 10'($urandom_range(0, 7));
      endcase
      step(a, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 299) == 0));
    end

    for (int i = 0; i < 1024; i++) begin
      step(10'(i), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      check_ctr("sweep_ctr", 10'(i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
